alu_pipelined_stream: RTL and testbench

// - Parametrised successor to the fixed-depth pipelined ALU: configurable width and pipeline depth.
// - Full valid/ready streaming handshake on both sides, with per-stage backpressure and bubble collapse.
// - Wider op set, and a tag field carried alongside each op.
// - Sits between an operand-issue stage and a writeback/result FIFO; accepts one op per cycle when unstalled.

---
 rtl/alu_pipelined_stream.sv | 192 +++++++++++++++++++
 tb/tb_alu_pipelined_stream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipelined_stream.sv
// alu_pipelined_stream: streaming ALU, combinational compute at entry, then STAGES register stages.
// Latency: STAGES cycles when unstalled; throughput one op per cycle.
// Backpressure: per-stage valid bits with a combinational ready chain; empty stages fill while later ones stall.
//
// Ports:
//   clk_i, rst_i (sync, active-high)
//   valid_i/ready_o, A_i, B_i, ALUControl_i, tag_i    -- op input side
//   valid_o/ready_i, Result_o, tag_o, Z_o/N_o/C_o/OF_o -- result output side
// Optional feature macro: ALU_PIPELINED_STREAM_SAT_EN adds opcodes 0xA ADDS and 0xB SUBS
// (signed saturating add/sub). Without it those opcodes are undefined (Result=0, Z=1).
module alu_pipelined_stream #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [WIDTH-1:0]  A_i,
   input  logic [WIDTH-1:0]  B_i,
   input  logic [3:0]        ALUControl_i,
   input  logic [TAG_W-1:0]  tag_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [WIDTH-1:0]  Result_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic              Z_o,
   output logic              N_o,
   output logic              C_o,
   output logic              OF_o
);

   localparam int SW = $clog2(WIDTH);

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic [TAG_W-1:0] tag;
      logic             z;
      logic             n;
      logic             c;
      logic             of;
   } stage_t;

   // ------------------------------------------------------------------
   // Entry compute
   // ------------------------------------------------------------------
   logic [SW-1:0]    shamt;
   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;
   logic             add_of;
   logic             sub_of;
   logic [WIDTH-1:0] res_c;
   logic             c_c;
   logic             of_c;
   stage_t           in_d;

   assign shamt = B_i[SW-1:0];
   assign add_w = {1'b0, A_i} + {1'b0, B_i};
   // SUB as A + ~B + 1 so that the carry-out reads as "A >= B unsigned".
   assign sub_w = {1'b0, A_i} + {1'b0, ~B_i} + {{WIDTH{1'b0}}, 1'b1};
   assign add_of = (A_i[WIDTH-1] == B_i[WIDTH-1]) && (add_w[WIDTH-1] != A_i[WIDTH-1]);
   assign sub_of = (A_i[WIDTH-1] != B_i[WIDTH-1]) && (sub_w[WIDTH-1] != A_i[WIDTH-1]);

`ifdef ALU_PIPELINED_STREAM_SAT_EN
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   always_comb begin
      res_c = '0;
      c_c   = 1'b0;
      of_c  = 1'b0;
      case (ALUControl_i)
         4'h0: begin
            res_c = add_w[WIDTH-1:0];
            c_c   = add_w[WIDTH];
            of_c  = add_of;
         end
         4'h1: begin
            res_c = sub_w[WIDTH-1:0];
            c_c   = sub_w[WIDTH];
            of_c  = sub_of;
         end
         4'h2: res_c = A_i & B_i;
         4'h3: res_c = A_i | B_i;
         4'h4: res_c = A_i ^ B_i;
         4'h5: res_c = {{(WIDTH-1){1'b0}}, ($signed(A_i) < $signed(B_i))};
         4'h6: res_c = {{(WIDTH-1){1'b0}}, (A_i < B_i)};
         4'h7: res_c = A_i << shamt;
         4'h8: res_c = A_i >> shamt;
         4'h9: res_c = $signed(A_i) >>> shamt;
`ifdef ALU_PIPELINED_STREAM_SAT_EN
         // On overflow the true result has the sign of A, so clamp towards it.
         4'hA: begin
            res_c = add_of ? (A_i[WIDTH-1] ? SMIN : SMAX) : add_w[WIDTH-1:0];
            c_c   = add_w[WIDTH];
            of_c  = add_of;
         end
         4'hB: begin
            res_c = sub_of ? (A_i[WIDTH-1] ? SMIN : SMAX) : sub_w[WIDTH-1:0];
            c_c   = sub_w[WIDTH];
            of_c  = sub_of;
         end
`endif
         default: begin
            res_c = '0;
            c_c   = 1'b0;
            of_c  = 1'b0;
         end
      endcase
   end

   always_comb begin
      in_d     = '0;
      in_d.res = res_c;
      in_d.tag = tag_i;
      in_d.z   = (res_c == '0);
      in_d.n   = res_c[WIDTH-1];
      in_d.c   = c_c;
      in_d.of  = of_c;
   end

   // ------------------------------------------------------------------
   // Pipeline with per-stage valid and bubble collapse
   // ------------------------------------------------------------------
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_d;
   logic [STAGES-1:0] load;
   stage_t            st_q [STAGES];
   stage_t            st_d [STAGES];
   logic              acc;

   // A stage loads when it is empty or its content moves on; the chain runs
   // from the output back to the input in one combinational pass.
   always_comb begin
      logic chain;
      load  = '0;
      chain = ~v_q[STAGES-1] | ready_i;
      load[STAGES-1] = chain;
      for (int k = STAGES-2; k >= 0; k--) begin
         chain   = ~v_q[k] | chain;
         load[k] = chain;
      end
   end

   assign ready_o = load[0] & ~rst_i;
   assign acc     = valid_i & ready_o;

   always_comb begin
      logic   prev_v;
      stage_t prev_d;
      v_d    = v_q;
      prev_v = acc;
      prev_d = in_d;
      for (int k = 0; k < STAGES; k++) begin
         st_d[k] = st_q[k];
         if (load[k]) begin
            v_d[k] = prev_v;
            // Payload only changes when a real op arrives, so held data stays put.
            if (prev_v) begin
               st_d[k] = prev_d;
            end
         end
         prev_v = v_q[k];
         prev_d = st_q[k];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            st_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         for (int k = 0; k < STAGES; k++) begin
            st_q[k] <= st_d[k];
         end
      end
   end

   assign valid_o  = v_q[STAGES-1];
   assign Result_o = st_q[STAGES-1].res;
   assign tag_o    = st_q[STAGES-1].tag;
   assign Z_o      = st_q[STAGES-1].z;
   assign N_o      = st_q[STAGES-1].n;
   assign C_o      = st_q[STAGES-1].c;
   assign OF_o     = st_q[STAGES-1].of;

endmodule

// File: tb/tb_alu_pipelined_stream.sv
module tb_alu_pipelined_stream;
   localparam int W = 8;
   localparam int S = 2;
   localparam int T = 4;

   logic         clk_i;
   logic         rst_i;
   logic         valid_i;
   logic         ready_o;
   logic [W-1:0] A_i;
   logic [W-1:0] B_i;
   logic [3:0]   ALUControl_i;
   logic [T-1:0] tag_i;
   logic         valid_o;
   logic         ready_i;
   logic [W-1:0] Result_o;
   logic [T-1:0] tag_o;
   logic         Z_o, N_o, C_o, OF_o;

   alu_pipelined_stream #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .A_i(A_i), .B_i(B_i), .ALUControl_i(ALUControl_i), .tag_i(tag_i),
      .valid_o(valid_o), .ready_i(ready_i), .Result_o(Result_o), .tag_o(tag_o),
      .Z_o(Z_o), .N_o(N_o), .C_o(C_o), .OF_o(OF_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [7:0] res;
      logic [3:0] tag;
      logic       z;
      logic       n;
      logic       c;
      logic       of;
   } exp_t;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] tag;
      exp_t       e;
   } vec_t;

   exp_t q[$];
   vec_t vec[$];
   int   errors = 0;
   int   checks = 0;
   logic prev_stall = 1'b0;
   exp_t prev_out;

   function automatic exp_t actual();
      return {Result_o, tag_o, Z_o, N_o, C_o, OF_o};
   endfunction

   // Independent reference model built on integer arithmetic.
   function automatic exp_t model(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic [3:0] tag);
      exp_t m;
      int sa, sb, ua, ub, r, t, sh;
      logic c, of;
      sa = $signed(a); sb = $signed(b); ua = a; ub = b; sh = ub % 8;
      r = 0; c = 1'b0; of = 1'b0;
      case (op)
         4'h0: begin r = ua + ub; c = (ua + ub) > 255; of = (sa + sb > 127) || (sa + sb < -128); end
         4'h1: begin r = ua - ub; c = ua >= ub; of = (sa - sb > 127) || (sa - sb < -128); end
         4'h2: r = ua & ub;
         4'h3: r = ua | ub;
         4'h4: r = ua ^ ub;
         4'h5: r = (sa < sb) ? 1 : 0;
         4'h6: r = (ua < ub) ? 1 : 0;
         4'h7: r = ua << sh;
         4'h8: r = ua >> sh;
         4'h9: r = sa >>> sh;
`ifdef ALU_PIPELINED_STREAM_SAT_EN
         4'hA: begin
            t = sa + sb; c = (ua + ub) > 255;
            if (t > 127) begin r = 127; of = 1'b1; end
            else if (t < -128) begin r = -128; of = 1'b1; end
            else r = t;
         end
         4'hB: begin
            t = sa - sb; c = ua >= ub;
            if (t > 127) begin r = 127; of = 1'b1; end
            else if (t < -128) begin r = -128; of = 1'b1; end
            else r = t;
         end
`endif
         default: r = 0;
      endcase
      m.res = r[7:0];
      m.tag = tag;
      m.z   = (m.res == 8'h00);
      m.n   = m.res[7];
      m.c   = c;
      m.of  = of;
      return m;
   endfunction

   function automatic vec_t mk(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic [3:0] tag,
                               logic [7:0] res, logic z, logic n, logic c, logic of);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.tag = tag;
      v.e.res = res; v.e.tag = tag; v.e.z = z; v.e.n = n; v.e.c = c; v.e.of = of;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // One clock cycle: drive at negedge, evaluate handshakes 1ns later.
   task automatic step(input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] tag, input exp_t e, input logic rdy, output logic acc);
      exp_t x;
      @(negedge clk_i);
      valid_i = v; ALUControl_i = op; A_i = a; B_i = b; tag_i = tag; ready_i = rdy;
      #1;
      if (prev_stall) chk("hold_stable", {15'd0, valid_o, actual()}, {15'd0, 1'b1, prev_out});
      chk("ready_o", {31'd0, ready_o}, {31'd0, (q.size() < S) || rdy});
      acc = v && ready_o;
      if (valid_o && rdy) begin
         if (q.size() == 0) begin
            chk("spurious_valid_o", {31'd0, valid_o}, 32'd0);
         end else begin
            x = q.pop_front();
            chk("result", {16'd0, actual()}, {16'd0, x});
         end
      end
      if (acc) q.push_back(e);
      prev_stall = valid_o && !rdy;
      prev_out   = actual();
   endtask

   task automatic idle(input logic rdy);
      logic a;
      step(1'b0, 4'h0, 8'h00, 8'h00, 4'h0, '0, rdy, a);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
      #1 chk("rst_ready_o_low", {31'd0, ready_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      q.delete();
      prev_stall = 1'b0;
      #1;
      chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
      chk("rst_outputs", {16'd0, actual()}, 32'd0);
      chk("rst_ready_o_high", {31'd0, ready_o}, 32'd1);
   endtask

   task automatic drain();
      for (int t = 0; t < 30 && q.size() > 0; t++) idle(1'b1);
      chk("drain_empty", q.size(), 32'd0);
   endtask

   // Single ADD into an empty pipe: visible exactly S cycles after acceptance.
   task automatic latency(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
      logic acc;
      step(1'b1, 4'h0, a, b, tag, model(4'h0, a, b, tag), 1'b1, acc);
      chk("lat_accept", {31'd0, acc}, 32'd1);
      idle(1'b1);
      chk("lat_cycle1_valid_o", {31'd0, valid_o}, 32'd0);
      idle(1'b1);
      chk("lat_cycle2_valid_o", {31'd0, valid_o}, 32'd1);
      chk("lat_consumed", q.size(), 32'd0);
   endtask

   logic       acc;
   logic       saw_low;
   int         next;
   int         sent;
   logic [3:0] r_op;
   logic [7:0] r_a, r_b;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
      A_i = '0; B_i = '0; ALUControl_i = '0; tag_i = '0;

      vec.push_back(mk(4'h0, 8'h05, 8'h08, 4'h3, 8'h0D, 0, 0, 0, 0));
      vec.push_back(mk(4'h1, 8'h07, 8'h07, 4'h1, 8'h00, 1, 0, 1, 0));
      vec.push_back(mk(4'h1, 8'h00, 8'h09, 4'h2, 8'hF7, 0, 1, 0, 0));
      vec.push_back(mk(4'h0, 8'h7F, 8'h01, 4'h4, 8'h80, 0, 1, 0, 1));
      vec.push_back(mk(4'h0, 8'hFF, 8'h01, 4'h5, 8'h00, 1, 0, 1, 0));
      vec.push_back(mk(4'h9, 8'h80, 8'h03, 4'h6, 8'hF0, 0, 1, 0, 0));
      vec.push_back(mk(4'h5, 8'hFF, 8'h01, 4'h7, 8'h01, 0, 0, 0, 0));
      vec.push_back(mk(4'h6, 8'hFF, 8'h01, 4'h8, 8'h00, 1, 0, 0, 0));
      vec.push_back(mk(4'h2, 8'hF0, 8'h3C, 4'h9, 8'h30, 0, 0, 0, 0));
      vec.push_back(mk(4'h3, 8'hF0, 8'h0F, 4'hA, 8'hFF, 0, 1, 0, 0));
      vec.push_back(mk(4'h4, 8'hAA, 8'hFF, 4'hB, 8'h55, 0, 0, 0, 0));
      vec.push_back(mk(4'h7, 8'h01, 8'h0F, 4'hC, 8'h80, 0, 1, 0, 0));
      vec.push_back(mk(4'h8, 8'h80, 8'h0B, 4'hD, 8'h10, 0, 0, 0, 0));
      vec.push_back(mk(4'h1, 8'h03, 8'h05, 4'h1, 8'hFE, 0, 1, 0, 0));
      vec.push_back(mk(4'h0, 8'h80, 8'h80, 4'h2, 8'h00, 1, 0, 1, 1));
`ifdef ALU_PIPELINED_STREAM_SAT_EN
      vec.push_back(mk(4'hA, 8'h7F, 8'h01, 4'hE, 8'h7F, 0, 0, 0, 1));
      vec.push_back(mk(4'hB, 8'h80, 8'h01, 4'hF, 8'h80, 0, 1, 1, 1));
`else
      vec.push_back(mk(4'hA, 8'h7F, 8'h01, 4'hE, 8'h00, 1, 0, 0, 0));
      vec.push_back(mk(4'hB, 8'h80, 8'h01, 4'hF, 8'h00, 1, 0, 0, 0));
`endif
      vec.push_back(mk(4'hF, 8'h12, 8'h34, 4'h0, 8'h00, 1, 0, 0, 0));

      do_reset();

      latency(8'h05, 8'h08, 4'h3);

      // Directed vectors, back to back
      foreach (vec[i]) begin
         acc = 1'b0;
         for (int t = 0; t < 20 && !acc; t++)
            step(1'b1, vec[i].op, vec[i].a, vec[i].b, vec[i].tag, vec[i].e, 1'b1, acc);
         chk("vec_accept", {31'd0, acc}, 32'd1);
      end
      drain();

      // Six-op stream with a downstream stall on cycles 3..6
      next = 0; saw_low = 1'b0;
      for (int cyc = 0; cyc < 40 && (next < 6 || q.size() > 0); cyc++) begin
         step(next < 6, 4'h0, 8'(next), 8'h10, 4'(next),
              model(4'h0, 8'(next), 8'h10, 4'(next)), !(cyc >= 3 && cyc <= 6), acc);
         if (!ready_o) saw_low = 1'b1;
         if (acc) next++;
      end
      chk("stall_ready_low_seen", {31'd0, saw_low}, 32'd1);
      chk("stall_all_emerged", q.size() + (6 - next), 32'd0);

      // Reset with two ops held in the pipe
      step(1'b1, 4'h0, 8'h11, 8'h22, 4'hA, model(4'h0, 8'h11, 8'h22, 4'hA), 1'b0, acc);
      step(1'b1, 4'h0, 8'h33, 8'h44, 4'hB, model(4'h0, 8'h33, 8'h44, 4'hB), 1'b0, acc);
      idle(1'b0);
      chk("pre_reset_full", {31'd0, valid_o}, 32'd1);
      do_reset();
      for (int t = 0; t < 4; t++) begin
         idle(1'b1);
         chk("post_reset_quiet", {31'd0, valid_o}, 32'd0);
      end
      latency(8'h21, 8'h01, 4'h6);

      // Random traffic with random backpressure
      sent = 0;
      for (int t = 0; t < 3000 && sent < 150; t++) begin
         r_op = 4'($urandom_range(0, 15));
         r_a  = 8'($urandom_range(0, 255));
         r_b  = 8'($urandom_range(0, 255));
         step($urandom_range(0, 9) < 8, r_op, r_a, r_b, 4'(sent),
              model(r_op, r_a, r_b, 4'(sent)), $urandom_range(0, 3) != 0, acc);
         if (acc) sent++;
      end
      chk("random_sent", sent, 32'd150);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
